ram512_arbiter: RTL and testbench
=================================

Name: ram512_arbiter

Overview:
Two-requester round-robin controller for the 512x16 single-port ram512 array. After reset it runs a clear sequence that writes zero to every location, then accepts one access per cycle from either requester through a req/gnt handshake. It drives the RAM's en/r/w/add/d_in pins and returns read data tagged with a per-port valid pulse. It sits between two datapath clients and a single ram512 instance.

Parameters:
DW, 16, data width (must match ram512)
AW, 9, address width (depth = 2**AW = 512)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
req0  input  1  port 0 access request; held with cmd fields until gnt0
we0  input  1  port 0: 1 = write, 0 = read
addr0  input  AW  port 0 address
wdata0  input  DW  port 0 write data
gnt0  output  1  port 0 request accepted this cycle (combinational)
rvalid0  output  1  port 0 read data valid on rdata
req1, we1, addr1, wdata1, gnt1, rvalid1  same as port 0, for port 1
rdata  output  DW  read data, shared by both ports (= ram_dout)
init_done  output  1  clear sequence finished
ram_en  output  1  RAM enable
ram_r  output  1  RAM read strobe
ram_w  output  1  RAM write strobe
ram_add  output  AW  RAM address
ram_din  output  DW  RAM write data
ram_dout  input  DW  RAM read data, valid one cycle after a read command

Behaviour:
- RAM command encoding: write = en1 w1 r0; read = en1 r1 w0; idle = all 0. ram_* outputs are registered.
- Reset (async, rst_n=0): state=INIT, clear counter=0, rr_last=1 (port 0 wins the first tie). ram_* =0, gnt*/rvalid* =0, init_done=0. Asserting reset mid-operation aborts any access, drops in-flight rvalid and restarts INIT.
- FSM INIT: each cycle issue a write of 0 to address cnt, then cnt+1. After the write to 511 the FSM goes to RUN and init_done=1 from the next cycle, held until reset. No gnt in INIT; requesters keep req asserted.
- FSM RUN: arbitration is combinational in cycle N.
  - Only reqX -> gntX=1.
  - Both -> grant the port not equal to rr_last; update rr_last to the winner on each grant.
  - Neither -> no grant; ram_* idle in N+1.
- Granted cmd is registered onto ram_* and driven during N+1.
- Read latency: gnt at N, ram read in N+1, ram_dout/rdata valid in N+2 with rvalidX=1 for exactly one cycle. Tag pipeline: 2-stage {valid, port} shift register.
- Writes produce no rvalid.
- Throughput: one access per cycle. Back-to-back grants to the same port are allowed when the other port is idle.
- A read granted the cycle after a write to the same address returns the new data, because RAM commands execute in grant order.
- Address is AW bits; no wrap logic needed beyond natural 9-bit width. The clear counter is AW+1 bits to detect completion.
- rdata is undefined when both rvalid are 0. Bench checks rdata only under rvalid.

Decomposition:
- Shared package: DW/AW constants, FSM state encoding (INIT, RUN), RAM command encoding constants.
- One sub-module is natural: rr_arb2 (combinational 2-way round-robin grant with registered rr_last).
- Read-tag pipeline and clear counter stay in the top module.

Test Plan:
- Reset release -> 512 consecutive writes (ram_w=1, ram_din=0, ram_add 0..511). init_done rises on the cycle after the add=511 write. No gnt during INIT despite req0=1.
- After init, port 0 read addr 2 -> gnt0 at N, ram_r=1 add=2 at N+1, rvalid0=1 rdata=0x0000 at N+2.
- Port 0 writes d_in=addr for addr 2,66,130,...,450 (stride 64); port 1 reads the same addresses -> each rvalid1 returns 0x0002, 0x0042, ... 0x01C2.
- req0 and req1 held for 4 cycles (reads) -> grants alternate 0,1,0,1. rvalid0/rvalid1 alternate 2 cycles later with the correct data.
- Port 0 write addr 66 data 0xBEEF at N, port 1 read addr 66 at N+1 -> rvalid1 at N+3 with rdata=0xBEEF.
- rst_n pulsed low at INIT count 200, then in RUN with a read in flight -> outputs clear immediately, no stale rvalid, INIT restarts from address 0.

Source files
------------

// File: rtl/ram512_arbiter_pkg.sv
// Shared constants and encodings for the ram512 two-port round-robin controller.
// The RAM command is carried as an {en, r, w} triple so the pins decode straight from it.
package ram512_arbiter_pkg;

    localparam int RAM_DW = 16;
    localparam int RAM_AW = 9;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic en;
        logic r;
        logic w;
    } ram_cmd_t;

    localparam ram_cmd_t CMD_IDLE  = 3'b000;
    localparam ram_cmd_t CMD_READ  = 3'b110;
    localparam ram_cmd_t CMD_WRITE = 3'b101;

endpackage

// File: rtl/ram512_arbiter_rr_arb2.sv
// Two-way round-robin grant: combinational grant, registered record of the last winner.
// Grants are only issued while i_en is high (controller in RUN).
module ram512_arbiter_rr_arb2 (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    input  logic i_req0,
    input  logic i_req1,
    output logic o_gnt0,
    output logic o_gnt1
);

    logic r_rr_last;

    // On a tie the port that did not win last time gets the grant.
    always_comb begin
        o_gnt0 = 1'b0;
        o_gnt1 = 1'b0;
        if (i_en) begin
            if (i_req0 && i_req1) begin
                o_gnt0 = r_rr_last;
                o_gnt1 = !r_rr_last;
            end else begin
                o_gnt0 = i_req0;
                o_gnt1 = i_req1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_last <= 1'b1;
        end else if (o_gnt0) begin
            r_rr_last <= 1'b0;
        end else if (o_gnt1) begin
            r_rr_last <= 1'b1;
        end
    end

endmodule

// File: rtl/ram512_arbiter.sv
// Round-robin front end for a 512x16 single-port RAM: clears the array after reset,
// then issues one granted access per cycle and tags read data back to its port.
module ram512_arbiter
    import ram512_arbiter_pkg::*;
#(
    parameter int DW = RAM_DW,
    parameter int AW = RAM_AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          gnt0,
    output logic          rvalid0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          gnt1,
    output logic          rvalid1,
    output logic [DW-1:0] rdata,
    output logic          init_done,
    output logic          ram_en,
    output logic          ram_r,
    output logic          ram_w,
    output logic [AW-1:0] ram_add,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout,
    output state_t        dbg_state
);

    localparam logic [AW:0] CNT_LAST = {1'b0, {AW{1'b1}}};

    state_t        r_state;
    logic [AW:0]   r_cnt;
    logic          r_init_done;
    ram_cmd_t      r_cmd;
    logic [AW-1:0] r_add;
    logic [DW-1:0] r_din;
    logic [1:0]    r_tag_v;
    logic [1:0]    r_tag_p;

    logic          w_gnt0;
    logic          w_gnt1;
    logic          w_we;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_wdata;
    logic          w_rd_issue;

    ram512_arbiter_rr_arb2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_en   (r_state == ST_RUN),
        .i_req0 (req0),
        .i_req1 (req1),
        .o_gnt0 (w_gnt0),
        .o_gnt1 (w_gnt1)
    );

    assign w_we       = w_gnt1 ? we1    : we0;
    assign w_addr     = w_gnt1 ? addr1  : addr0;
    assign w_wdata    = w_gnt1 ? wdata1 : wdata0;
    assign w_rd_issue = (w_gnt0 || w_gnt1) && !w_we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_INIT;
            r_cnt       <= '0;
            r_init_done <= 1'b0;
            r_cmd       <= CMD_IDLE;
            r_add       <= '0;
            r_din       <= '0;
            r_tag_v     <= '0;
            r_tag_p     <= '0;
        end else begin
            // Tag pipeline lines up {valid, port} with ram_dout two cycles after the grant.
            r_tag_v <= {r_tag_v[0], w_rd_issue};
            r_tag_p <= {r_tag_p[0], w_gnt1};
            r_cmd   <= CMD_IDLE;
            r_add   <= '0;
            r_din   <= '0;
            case (r_state)
                ST_INIT: begin
                    r_cmd <= CMD_WRITE;
                    r_add <= r_cnt[AW-1:0];
                    r_din <= '0;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_LAST) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_init_done <= 1'b1;
                    if (w_gnt0 || w_gnt1) begin
                        r_cmd <= w_we ? CMD_WRITE : CMD_READ;
                        r_add <= w_addr;
                        r_din <= w_wdata;
                    end
                end
                default: r_state <= ST_INIT;
            endcase
        end
    end

    assign gnt0      = w_gnt0;
    assign gnt1      = w_gnt1;
    assign rvalid0   = r_tag_v[1] && !r_tag_p[1];
    assign rvalid1   = r_tag_v[1] && r_tag_p[1];
    assign rdata     = ram_dout;
    assign init_done = r_init_done;
    assign ram_en    = r_cmd.en;
    assign ram_r     = r_cmd.r;
    assign ram_w     = r_cmd.w;
    assign ram_add   = r_add;
    assign ram_din   = r_din;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_ram512_arbiter.sv
// Bench for ram512_arbiter: behavioural RAM, shadow-memory reference model with an
// expected-read queue, a vector table for arbitration order, and reset corner cases.
module tb_ram512_arbiter;
    import ram512_arbiter_pkg::*;

    localparam int DW    = RAM_DW;
    localparam int AW    = RAM_AW;
    localparam int DEPTH = 1 << AW;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic          gnt0, gnt1, rvalid0, rvalid1, init_done;
    logic          ram_en, ram_r, ram_w;
    logic [AW-1:0] ram_add;
    logic [DW-1:0] ram_din, rdata;
    logic [DW-1:0] ram_dout;
    state_t        dbg_state;

    ram512_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .gnt0(gnt0), .rvalid0(rvalid0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .gnt1(gnt1), .rvalid1(rvalid1),
        .rdata(rdata), .init_done(init_done),
        .ram_en(ram_en), .ram_r(ram_r), .ram_w(ram_w), .ram_add(ram_add),
        .ram_din(ram_din), .ram_dout(ram_dout), .dbg_state(dbg_state)
    );

    // Behavioural ram512: synchronous write, read data one cycle after the read command.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (ram_en && ram_w) mem[ram_add] <= ram_din;
        if (ram_en && ram_r) ram_dout <= mem[ram_add];
    end

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [DW-1:0] sh [DEPTH];
    logic [DW-1:0] exp_q [$];
    int            due_q [$];
    bit            port_q[$];
    bit            rr_last;
    bit            pv_valid, pv_we;
    logic [AW-1:0] pv_add;
    logic [DW-1:0] pv_din;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        foreach (sh[i]) sh[i] = '0;
        exp_q.delete();
        due_q.delete();
        port_q.delete();
        rr_last  = 1'b1;
        pv_valid = 1'b0;
    endtask

    // Asserts reset now, checks outputs clear at once, releases and follows the clear
    // sequence. abort_at >= 0 returns right after the write to that address is seen.
    task automatic reset_and_init(input int abort_at);
        rst_n = 1'b0;
        req0 = 1'b1; we0 = 1'b0; addr0 = 9'd2; wdata0 = '0;
        req1 = 1'b0; we1 = 1'b0; addr1 = '0;   wdata1 = '0;
        #1;
        chk("rst_ram_cmd", {ram_en, ram_r, ram_w}, 3'b000);
        chk("rst_ram_add", ram_add, 0);
        chk("rst_ram_din", ram_din, 0);
        chk("rst_gnt", {gnt0, gnt1}, 2'b00);
        chk("rst_rvalid", {rvalid0, rvalid1}, 2'b00);
        chk("rst_init_done", init_done, 0);
        chk("rst_state", dbg_state, ST_INIT);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            #1;
            chk("init_cmd", {ram_en, ram_r, ram_w}, 3'b101);
            chk("init_add", ram_add, i);
            chk("init_din", ram_din, 0);
            chk("init_done_early", init_done, 0);
            chk("init_gnt", {gnt0, gnt1}, 2'b00);
            chk("init_rvalid", {rvalid0, rvalid1}, 2'b00);
            if (i == abort_at) return;
            if (i == DEPTH - 2) req0 = 1'b0;
        end
        @(negedge clk);
        #1;
        chk("init_done", init_done, 1);
        chk("post_init_idle", {ram_en, ram_r, ram_w}, 3'b000);
        chk("post_init_state", dbg_state, ST_RUN);
        model_reset();
    endtask

    // One clock cycle: drive inputs at the falling edge, then compare every output
    // against the reference model and advance the model.
    task automatic cycle(input logic r0, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                         input logic r1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                         output logic g0, output logic g1);
        bit e0, e1;
        int win;
        @(negedge clk);
        req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
        req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
        #1;
        cyc++;
        if (pv_valid) begin
            chk("ram_cmd", {ram_en, ram_r, ram_w}, pv_we ? 3'b101 : 3'b110);
            chk("ram_add", ram_add, pv_add);
            if (pv_we) chk("ram_din", ram_din, pv_din);
        end else begin
            chk("ram_idle", {ram_en, ram_r, ram_w}, 3'b000);
        end
        e0 = (due_q.size() > 0) && (due_q[0] == cyc) && (port_q[0] == 1'b0);
        e1 = (due_q.size() > 0) && (due_q[0] == cyc) && (port_q[0] == 1'b1);
        chk("rvalid0", rvalid0, e0);
        chk("rvalid1", rvalid1, e1);
        if (e0 || e1) begin
            chk("rdata", rdata, exp_q[0]);
            void'(exp_q.pop_front());
            void'(due_q.pop_front());
            void'(port_q.pop_front());
        end
        win = -1;
        if (r0 && r1) win = rr_last ? 0 : 1;
        else if (r0)  win = 0;
        else if (r1)  win = 1;
        g0 = (win == 0);
        g1 = (win == 1);
        chk("gnt0", gnt0, g0);
        chk("gnt1", gnt1, g1);
        pv_valid = (win >= 0);
        if (win >= 0) begin
            rr_last = win[0];
            pv_we   = (win == 1) ? w1 : w0;
            pv_add  = (win == 1) ? a1 : a0;
            pv_din  = (win == 1) ? d1 : d0;
            if (pv_we) begin
                sh[pv_add] = pv_din;
            end else begin
                exp_q.push_back(sh[pv_add]);
                due_q.push_back(cyc + 2);
                port_q.push_back(win[0]);
            end
        end
    endtask

    task automatic idle(input int n);
        logic g0, g1;
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, g0, g1);
    endtask

    typedef struct {
        logic          r0, w0;
        logic [AW-1:0] a0;
        logic [DW-1:0] d0;
        logic          r1, w1;
        logic [AW-1:0] a1;
        logic [DW-1:0] d1;
        logic          eg0, eg1;
    } vec_t;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t          tbl[6];
        logic          g0, g1;
        logic          p0, p1, w0r, w1r;
        logic [AW-1:0] a0r, a1r, a;
        logic [DW-1:0] d0r, d1r;

        // Both ports requesting reads; port 0 wins the first tie, then strict alternation.
        tbl[0] = '{1'b1, 1'b0, 9'd2,   16'd0, 1'b1, 1'b0, 9'd130, 16'd0, 1'b1, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 9'd66,  16'd0, 1'b1, 1'b0, 9'd130, 16'd0, 1'b0, 1'b1};
        tbl[2] = '{1'b1, 1'b0, 9'd66,  16'd0, 1'b1, 1'b0, 9'd194, 16'd0, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 1'b0, 9'd258, 16'd0, 1'b1, 1'b0, 9'd194, 16'd0, 1'b0, 1'b1};
        tbl[4] = '{1'b1, 1'b0, 9'd258, 16'd0, 1'b0, 1'b0, 9'd0,   16'd0, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 1'b0, 9'd0,   16'd0, 1'b0, 1'b0, 9'd0,   16'd0, 1'b0, 1'b0};

        @(negedge clk);
        reset_and_init(-1);

        // Single read of a cleared location.
        cycle(1'b1, 1'b0, 9'd2, 16'd0, 1'b0, 1'b0, '0, '0, g0, g1);
        idle(1);
        chk("rd2_cmd", {ram_en, ram_r, ram_w, ram_add}, {3'b110, 9'd2});
        idle(1);
        chk("rd2_rvalid0", rvalid0, 1);
        chk("rd2_rdata", rdata, 16'h0000);

        // Stride-64 writes from port 0, read back through port 1.
        for (int k = 0; k < 8; k++) begin
            a = AW'(2 + 64 * k);
            cycle(1'b1, 1'b1, a, DW'(a), 1'b0, 1'b0, '0, '0, g0, g1);
        end
        for (int k = 0; k < 8; k++) begin
            a = AW'(2 + 64 * k);
            cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, a, '0, g0, g1);
        end
        idle(2);

        for (int i = 0; i < 6; i++) begin
            cycle(tbl[i].r0, tbl[i].w0, tbl[i].a0, tbl[i].d0,
                  tbl[i].r1, tbl[i].w1, tbl[i].a1, tbl[i].d1, g0, g1);
            chk("tbl_gnt", {gnt0, gnt1}, {tbl[i].eg0, tbl[i].eg1});
        end
        idle(2);

        // Write then immediately read the same address from the other port.
        cycle(1'b1, 1'b1, 9'd66, 16'hBEEF, 1'b0, 1'b0, '0, '0, g0, g1);
        cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 9'd66, '0, g0, g1);
        idle(2);
        chk("raw_rvalid1", rvalid1, 1);
        chk("raw_rdata", rdata, 16'hBEEF);

        // Random traffic over a small address window; commands held until granted.
        p0 = 1'b0; p1 = 1'b0;
        w0r = 1'b0; w1r = 1'b0; a0r = '0; a1r = '0; d0r = '0; d1r = '0;
        for (int n = 0; n < 400; n++) begin
            if (!p0) begin
                p0  = 1'($urandom_range(0, 1));
                w0r = 1'($urandom_range(0, 1));
                a0r = AW'($urandom_range(0, 15));
                d0r = DW'($urandom());
            end
            if (!p1) begin
                p1  = 1'($urandom_range(0, 1));
                w1r = 1'($urandom_range(0, 1));
                a1r = AW'($urandom_range(0, 15));
                d1r = DW'($urandom());
            end
            cycle(p0, w0r, a0r, d0r, p1, w1r, a1r, d1r, g0, g1);
            if (g0) p0 = 1'b0;
            if (g1) p1 = 1'b0;
        end
        idle(3);

        // Reset part-way through the clear, then again with a read in flight.
        reset_and_init(200);
        reset_and_init(-1);
        cycle(1'b1, 1'b0, 9'd5, '0, 1'b0, 1'b0, '0, '0, g0, g1);
        idle(1);
        reset_and_init(-1);
        cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 9'd66, '0, g0, g1);
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
